// File: rtl/sine_width_gen.sv
// Phase accumulator + quarter-wave sine ROM producing PWM duty widths (0..PERIOD) per period tick.
// Optional macro SINE_WIDTH_AMP_EN adds an 8-bit amplitude scale with one extra registered stage.
module sine_width_gen #(
  parameter int PERIOD   = 1000,
  parameter int LUT_LOG2 = 6,
  parameter int PHASE_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tick,
  input  logic [PHASE_W-1:0] phase_inc,
`ifdef SINE_WIDTH_AMP_EN
  input  logic [7:0]         amp,
`endif
  output logic [31:0]        width,
  output logic               width_valid
);
  localparam int N     = 1 << LUT_LOG2;
  localparam int MID   = PERIOD / 2;
  localparam int ROM_W = $clog2(MID + 1);
`ifdef SINE_WIDTH_AMP_EN
  localparam int STAGES = 4;
`else
  localparam int STAGES = 3;
`endif

  // Taylor series is plenty accurate on [0, pi/2] and keeps elaboration free of math-library calls.
  function automatic real sin_q(input real x);
    real term, sum;
    sum  = x;
    term = x;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / (real'(2 * i) * real'(2 * i + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int lut_val(input int k);
    real a;
    a = real'(MID) * sin_q(3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(N));
    return $rtoi(a + 0.5);
  endfunction

  logic [ROM_W-1:0] lut [N];
  for (genvar k = 0; k < N; k++) begin : g_rom
    assign lut[k] = ROM_W'(lut_val(k));
  end

  logic                accept;
  logic [STAGES:1]     vld_q;
  wire  [STAGES:0]     vld_pipe = {vld_q, accept};
  logic [PHASE_W-1:0]  phase;
  logic [1:0]          quad_p1, quad_p2;
  logic [LUT_LOG2-1:0] idx_p1, addr_p1;
  logic [ROM_W-1:0]    rom_q;
  logic [1:0]          quad_last;
  logic [ROM_W-1:0]    off_last;
  logic                unused_phase_lsb;

  assign accept  = tick & en;
  assign quad_p1 = phase[PHASE_W-1 -: 2];
  assign idx_p1  = phase[PHASE_W-3 -: LUT_LOG2];
  // Quadrants 1 and 3 walk the quarter wave backwards.
  assign addr_p1 = quad_p1[0] ? ~idx_p1 : idx_p1;
  assign unused_phase_lsb = ^phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      phase <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (accept) phase <= phase + phase_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_q   <= '0;
      quad_p2 <= '0;
    end else begin
      rom_q   <= lut[addr_p1];
      quad_p2 <= quad_p1;
    end
  end

`ifdef SINE_WIDTH_AMP_EN
  logic [7:0]       amp_p1, amp_p2;
  logic [1:0]       quad_p3;
  logic [ROM_W-1:0] off_p3;
  logic [ROM_W+7:0] prod;

  assign prod = {8'd0, rom_q} * {{ROM_W{1'b0}}, amp_p2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      amp_p1  <= '0;
      amp_p2  <= '0;
      off_p3  <= '0;
      quad_p3 <= '0;
    end else begin
      if (accept) amp_p1 <= amp;
      amp_p2  <= amp_p1;
      off_p3  <= prod[ROM_W+7:8];
      quad_p3 <= quad_p2;
    end
  end

  assign off_last  = off_p3;
  assign quad_last = quad_p3;
`else
  assign off_last  = rom_q;
  assign quad_last = quad_p2;
`endif

  // Width only moves on a valid slot so it holds between updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      width       <= 32'(MID);
      width_valid <= 1'b0;
    end else begin
      width_valid <= vld_pipe[STAGES-1];
      if (vld_pipe[STAGES-1])
        width <= quad_last[1] ? 32'(MID) - 32'(off_last) : 32'(MID) + 32'(off_last);
    end
  end

endmodule

// File: tb/tb_sine_width_gen.sv
// Scoreboard bench for sine_width_gen (default build, PERIOD=1000, LUT_LOG2=6, PHASE_W=16).
module tb_sine_width_gen;
  localparam int PERIOD = 1000;

  typedef struct { int w; int c; } ev_t;

  logic        clk = 1'b0;
  logic        rst_n, en, tick;
  logic [15:0] phase_inc;
  logic [31:0] width;
  logic        width_valid;

  int          tests = 0, fails = 0, cyc = 0;
  logic [15:0] model_phase = '0;
  ev_t         exp_q[$], obs_q[$];
  ev_t         e, o;

  sine_width_gen #(.PERIOD(PERIOD), .LUT_LOG2(6), .PHASE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .phase_inc(phase_inc),
    .width(width), .width_valid(width_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (width_valid) obs_q.push_back('{int'(width), cyc});

  function automatic int exp_width(input logic [15:0] ph);
    int  k, l;
    real pi;
    pi = 3.14159265358979;
    k  = ph[14] ? 63 - int'(ph[13:8]) : int'(ph[13:8]);
    l  = $rtoi(500.0 * $sin(pi / 2.0 * (real'(k) + 0.5) / 64.0) + 0.5);
    return ph[15] ? 500 - l : 500 + l;
  endfunction

  // Drive tick for one cycle (caller lowers it); predict the pulse three cycles on.
  task automatic tick_cycle(input logic [15:0] inc);
    tick = 1'b1;
    phase_inc = inc;
    if (en && rst_n) begin
      model_phase = model_phase + inc;
      exp_q.push_back('{exp_width(model_phase), cyc + 3});
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    tick  = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_phase = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; tick = 1'b0;
    repeat (2) @(negedge clk);
    tick_cycle(16'h4000);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_phase = '0;
    tests++;
    if (width !== 32'd500 || width_valid !== 1'b0) begin
      fails++; $display("FAIL reset_state: width=%0d valid=%b, want 500/0", width, width_valid);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (obs_q.size() != 0 || width !== 32'd500) begin
      fails++; $display("FAIL reset_idle: pulses=%0d width=%0d, want 0/500", obs_q.size(), width);
    end
    obs_q.delete();
  endtask

  task automatic test_single();
    en = 1'b1;
    tick_cycle(16'h0000);
    tick = 1'b0;
    repeat (6) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL single: no pulse, want width %0d at cycle %0d", e.w, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o.w !== e.w || o.c !== e.c) begin
          fails++; $display("FAIL single: got %0d at cycle %0d, want %0d at %0d", o.w, o.c, e.w, e.c);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0 || width !== 32'd506) begin
      fails++; $display("FAIL single_value: extra=%0d width=%0d, want 0/506", obs_q.size(), width);
    end
    obs_q.delete();
  endtask

  task automatic test_quadrants();
    int tab[4] = '{1000, 494, 0, 506};
    for (int i = 0; i < 4; i++) begin
      tick_cycle(16'h4000);
      tick = 1'b0;
      repeat (999) @(negedge clk);
      tests++;
      if (width !== 32'(tab[i])) begin
        fails++; $display("FAIL quadrant_%0d: width=%0d, want %0d", i, width, tab[i]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL quadrants: no pulse, want width %0d at cycle %0d", e.w, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o.w !== e.w || o.c !== e.c) begin
          fails++; $display("FAIL quadrants: got %0d at cycle %0d, want %0d at %0d", o.w, o.c, e.w, e.c);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++; $display("FAIL quadrants_extra: %0d unexpected pulses, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_enable();
    logic [31:0] prior;
    prior = width;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_cycle(16'h4000);
      tick = 1'b0;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (obs_q.size() != 0 || width !== prior) begin
      fails++; $display("FAIL enable_off: pulses=%0d width=%0d, want 0/%0d", obs_q.size(), width, prior);
    end
    obs_q.delete();
    en = 1'b1;
    tick_cycle(16'h4000);
    tick = 1'b0;
    repeat (6) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL enable_on: no pulse, want width %0d at cycle %0d", e.w, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o.w !== e.w || o.c !== e.c) begin
          fails++; $display("FAIL enable_on: got %0d at cycle %0d, want %0d at %0d", o.w, o.c, e.w, e.c);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0 || width !== 32'd1000) begin
      fails++; $display("FAIL enable_step: extra=%0d width=%0d, want 0/1000", obs_q.size(), width);
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int tab[3] = '{518, 531, 543};
    int n;
    apply_reset(2);
    en = 1'b1;
    for (int i = 0; i < 3; i++) tick_cycle(16'h0100);
    tick = 1'b0;
    repeat (6) @(negedge clk);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL b2b: no pulse, want width %0d at cycle %0d", e.w, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o.w !== e.w || o.c !== e.c || o.w !== tab[n]) begin
          fails++; $display("FAIL b2b_%0d: got %0d at cycle %0d, want %0d at %0d", n, o.w, o.c, tab[n], e.c);
        end
      end
      n++;
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++; $display("FAIL b2b_extra: %0d unexpected pulses, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_flush();
    en = 1'b1;
    tick_cycle(16'h4000);
    tick  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_phase = '0;
    exp_q.delete();
    repeat (10) @(negedge clk);
    tests++;
    if (obs_q.size() != 0 || width !== 32'd500) begin
      fails++; $display("FAIL flush: pulses=%0d width=%0d, want 0/500", obs_q.size(), width);
    end
    obs_q.delete();
    tick_cycle(16'h0100);
    tick = 1'b0;
    repeat (6) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL flush_next: no pulse, want width %0d at cycle %0d", e.w, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o.w !== e.w || o.c !== e.c) begin
          fails++; $display("FAIL flush_next: got %0d at cycle %0d, want %0d at %0d", o.w, o.c, e.w, e.c);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0 || width !== 32'd518) begin
      fails++; $display("FAIL flush_value: extra=%0d width=%0d, want 0/518", obs_q.size(), width);
    end
    obs_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; tick = 1'b0; phase_inc = '0;
    repeat (5) @(negedge clk);
    test_reset();
    test_single();
    test_quadrants();
    test_enable();
    test_back_to_back();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sine_width_gen.md
Name: sine_width_gen

Overview:
Upstream feeder for the PWM comparator stage in the sine-wave generator. On each PWM-period tick it advances a phase accumulator and looks the phase up in a quarter-wave sine ROM. It then produces the next 32-bit duty width, expressed in clk cycles of one PWM period. The downstream counter/comparator turns that width into the PWM sine output.

Parameters:
PERIOD, 1000, PWM period in clk cycles; must be even and >= 8
LUT_LOG2, 6, log2 of quarter-wave ROM depth (N = 2^LUT_LOG2 entries)
PHASE_W, 16, phase accumulator width; must be >= LUT_LOG2+2

Ports:
clk  in  1  single system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
en  in  1  enable; ticks are ignored while low
tick  in  1  one-cycle pulse at each PWM period boundary
phase_inc  in  PHASE_W  frequency tuning word, sampled on accepted tick
width  out  32  current duty width in clk cycles, range 0..PERIOD
width_valid  out  1  one-cycle pulse when width takes a new value

Behaviour:
- Reset is synchronous: rst_n low at a clk edge resets state; the clock and reset scheme is the single clk plus synchronous active-low rst_n above.
- Reset values: phase=0, width=PERIOD/2, width_valid=0, all pipeline valid bits cleared.
- Accepted tick = tick & en. On an accepted tick: phase <= phase + phase_inc, mod 2^PHASE_W. The lookup uses this updated phase.
- Phase decode:
  - quad = phase[PHASE_W-1:PHASE_W-2]
  - idx = phase[PHASE_W-3:PHASE_W-2-LUT_LOG2]
  - lower bits are ignored (truncation)
- ROM contents:
  - A = PERIOD/2, MID = PERIOD/2
  - lut[k] = round(A*sin(pi/2*(k+0.5)/N)), computed at elaboration (constant real function); no external file.
- Width mapping by quadrant:
  - quad 0: MID + lut[idx]
  - quad 1: MID + lut[N-1-idx]
  - quad 2: MID - lut[idx]
  - quad 3: MID - lut[N-1-idx]
  - Result is always within 0..PERIOD; no saturation logic needed.
- Pipeline, fully pipelined, one new tick accepted every cycle:
  - cycle T: accepted tick
  - T+1: phase registered
  - T+2: ROM output registered (synchronous ROM, BRAM/LUTROM inferable)
  - T+3: width updated and width_valid=1 for exactly one cycle
- Latency is 3 cycles from tick to width.
- width holds its value between updates.
- en low: phase frozen, no new updates. Updates already in flight complete and still pulse width_valid.
- Back-to-back ticks on consecutive cycles produce consecutive width_valid pulses, in order.
- Phase wrap past 2^PHASE_W-1 is silent modular wrap.
- rst_n low mid-pipeline discards all in-flight updates: no width_valid pulse, width returns to PERIOD/2.
- tick while rst_n low is ignored.

Optional Feature:
Macro SINE_WIDTH_AMP_EN.
- Defined:
  - Adds input port amp [7:0], sampled together with phase_inc on an accepted tick.
  - Offset becomes (lut*amp)>>8, computed in one extra registered multiply stage.
  - Latency becomes 4 cycles.
  - amp=0 yields width=MID.
- Not defined:
  - No amp port; offset = lut; latency 3.

Test Plan:
All scenarios use PERIOD=1000, LUT_LOG2=6, PHASE_W=16, macro undefined.
1. Reset: hold rst_n=0 for 5 cycles, then release -> width=500, width_valid=0, no pulses until a tick.
2. en=1, phase_inc=0x0000, one tick -> exactly 3 cycles later width=506 (lut[0]=6) with a single width_valid pulse.
3. phase_inc=0x4000, ticks spaced 1000 cycles apart -> widths 1000, 494, 0, 506, repeating.
4. en=0, 10 ticks with phase_inc=0x4000 -> width stays at its prior value, no width_valid. Then set en=1 and issue one tick -> next phase step only (one increment applied).
5. phase_inc=0x0100, ticks on 3 consecutive cycles from phase 0 -> width_valid high for 3 consecutive cycles with widths 518, 531, 543.
6. Tick at cycle T, rst_n=0 at T+1 for one cycle -> no width_valid pulse ever appears and width=500; the next tick after release yields 500+lut[idx(phase_inc)].
